// File: rtl/mul_pipe_param.sv
// mul_pipe_param: parametrised pipelined shift-add multiplier with valid/ready.
// Optional sideband tag path enabled by defining MUL_PIPE_TAG_EN.
module mul_pipe_param #(
    parameter int WIDTH_A = 8,
    parameter int WIDTH_B = 8,
    parameter int TAG_W   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH_A-1:0]         in_a,
    input  logic [WIDTH_B-1:0]         in_b,
    input  logic                       in_signed,
`ifdef MUL_PIPE_TAG_EN
    input  logic [TAG_W-1:0]           in_tag,
    output logic [TAG_W-1:0]           out_tag,
`endif
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH_A+WIDTH_B-1:0] out_p
);

    localparam int WIDTH_P = WIDTH_A + WIDTH_B;
    localparam int LVL     = $clog2(WIDTH_B);
    localparam int LAT     = LVL + 2;

    if (WIDTH_A < 2 || WIDTH_B < 2 || TAG_W < 1) begin : g_bad_param
        $error("mul_pipe_param: illegal parameter values");
    end

    // vld_q[0] is S0, vld_q[1..LVL] the tree levels, vld_q[LAT-1] the output
    logic [LAT-1:0]     vld_q;
    logic               en;
    logic [WIDTH_A-1:0] a_q;
    logic [WIDTH_B-1:0] b_q;
    logic               s_q;
    logic [WIDTH_P-1:0] a_ext;
    logic [WIDTH_P-1:0] pp    [WIDTH_B];
    logic [WIDTH_P-1:0] cur   [2*WIDTH_B];
    logic [WIDTH_P-1:0] lvl_d [LVL][WIDTH_B];
    logic [WIDTH_P-1:0] lvl_q [LVL][WIDTH_B];
    logic [WIDTH_P-1:0] p_q;

    assign out_valid = vld_q[LAT-1];
    assign out_p     = p_q;
    // A stalled output freezes the whole pipe, bubbles included
    assign en        = !(out_valid && !out_ready);
    assign in_ready  = en;

    // S0: capture operands; idle slots carry zeros
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
            s_q <= 1'b0;
        end else if (en) begin
            a_q <= in_valid ? in_a : '0;
            b_q <= in_valid ? in_b : '0;
            s_q <= in_valid && in_signed;
        end
    end

    // Partial products; the signed MSB row carries negative weight
    always_comb begin
        a_ext = s_q ? {{WIDTH_B{a_q[WIDTH_A-1]}}, a_q}
                    : {{WIDTH_B{1'b0}}, a_q};
        for (int i = 0; i < WIDTH_B; i++) begin
            pp[i] = b_q[i] ? (a_ext << i) : '0;
        end
        if (s_q && b_q[WIDTH_B-1]) begin
            pp[WIDTH_B-1] = -(a_ext << (WIDTH_B - 1));
        end
    end

    // Pairwise sums per level; zero padding lets an odd term pass unchanged
    always_comb begin
        for (int j = 0; j < 2*WIDTH_B; j++) cur[j] = '0;
        for (int j = 0; j < WIDTH_B; j++) cur[j] = pp[j];
        for (int k = 0; k < LVL; k++) begin
            for (int j = 0; j < WIDTH_B; j++) begin
                lvl_d[k][j] = cur[2*j] + cur[2*j+1];
            end
            for (int j = 0; j < WIDTH_B; j++) cur[j] = lvl_q[k][j];
        end
    end

    // Adder-tree registers, output register and the valid chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            p_q   <= '0;
            for (int k = 0; k < LVL; k++) begin
                for (int j = 0; j < WIDTH_B; j++) lvl_q[k][j] <= '0;
            end
        end else if (en) begin
            vld_q <= {vld_q[LAT-2:0], in_valid};
            lvl_q <= lvl_d;
            p_q   <= vld_q[LAT-2] ? lvl_q[LVL-1][0] : '0;
        end
    end

`ifdef MUL_PIPE_TAG_EN
    logic [TAG_W-1:0] tag_q [LAT];

    assign out_tag = tag_q[LAT-1];

    // Tag shadows the data path stage for stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
        end else if (en) begin
            tag_q[0] <= in_valid ? in_tag : '0;
            for (int i = 1; i < LAT - 1; i++) tag_q[i] <= tag_q[i-1];
            tag_q[LAT-1] <= vld_q[LAT-2] ? tag_q[LAT-2] : '0;
        end
    end
`endif

endmodule

// File: tb/tb_mul_pipe_param.sv
// tb_mul_pipe_param: directed and random traffic on an 8x8 and a 12x5
// instance, checked against a plain-arithmetic product model.
`timescale 1ns/1ps
module tb_mul_pipe_param;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        iv0, ir0, ov0, or0, s0;
    logic [7:0]  a0, b0;
    logic [15:0] p0;
    logic [3:0]  t0, ot0;
    logic        iv1, ir1, ov1, or1, s1;
    logic [11:0] a1;
    logic [4:0]  b1;
    logic [16:0] p1;
    logic [3:0]  t1, ot1;
    logic [3:0]  et0, et1;

`ifdef MUL_PIPE_TAG_EN
    assign et0 = t0;
    assign et1 = t1;
`else
    assign et0 = '0;
    assign et1 = '0;
    assign ot0 = '0;
    assign ot1 = '0;
`endif

    mul_pipe_param u0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv0), .in_ready(ir0),
        .in_a(a0), .in_b(b0), .in_signed(s0),
`ifdef MUL_PIPE_TAG_EN
        .in_tag(t0), .out_tag(ot0),
`endif
        .out_valid(ov0), .out_ready(or0), .out_p(p0)
    );

    mul_pipe_param #(.WIDTH_A(12), .WIDTH_B(5), .TAG_W(4)) u1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv1), .in_ready(ir1),
        .in_a(a1), .in_b(b1), .in_signed(s1),
`ifdef MUL_PIPE_TAG_EN
        .in_tag(t1), .out_tag(ot1),
`endif
        .out_valid(ov1), .out_ready(or1), .out_p(p1)
    );

    typedef struct {
        longint p;
        longint tag;
        int     cin;
        int     sin;
        bit     seen;
    } ent_t;

    ent_t   sb [2][$];
    int     stl [2];
    int     nirlow [2];
    int     npop [2];
    bit     held [2];
    longint hp [2];
    longint ht [2];
    int     n_tests = 0;
    int     n_fail = 0;
    bit     done0, done1;

    function automatic longint model(int wa, int wb, longint a, longint b, bit s);
        longint sa, sbv;
        sa  = a;
        sbv = b;
        if (s && a[wa-1]) sa = a - (longint'(1) << wa);
        if (s && b[wb-1]) sbv = b - (longint'(1) << wb);
        return (sa * sbv) & ((longint'(1) << (wa + wb)) - 1);
    endfunction

    function automatic void chk(string nm, longint got, longint want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, got, want, cyc);
        end
    endfunction

    task automatic mon(input int d, input int lat, input int wa, input int wb,
                       input bit ov, input bit ordy, input bit irdy,
                       input longint p, input longint tg,
                       input bit iv, input longint a, input longint b,
                       input bit s, input longint itg);
        ent_t  e;
        string px;
        px = $sformatf("d%0d_", d);
        if (!rst_n) return;
        if (held[d]) begin
            chk({px, "hold_valid"}, longint'(ov), 1);
            chk({px, "hold_p"}, p, hp[d]);
            chk({px, "hold_tag"}, tg, ht[d]);
        end
        if (ov) begin
            if (sb[d].size() == 0) begin
                chk({px, "spurious_valid"}, 1, 0);
            end else begin
                e = sb[d][0];
                if (!e.seen) begin
                    chk({px, "latency"}, longint'(cyc - e.cin - (stl[d] - e.sin)), lat);
                    e.seen = 1'b1;
                    sb[d][0] = e;
                end
                chk({px, "p"}, p, e.p);
                chk({px, "tag"}, tg, e.tag);
                if (ordy) begin
                    void'(sb[d].pop_front());
                    npop[d]++;
                end
            end
        end else begin
            chk({px, "p_idle"}, p, 0);
            chk({px, "tag_idle"}, tg, 0);
            if (sb[d].size() > 0) begin
                e = sb[d][0];
                if (cyc - e.cin - (stl[d] - e.sin) >= lat)
                    chk({px, "missing_valid"}, 0, 1);
            end
        end
        chk({px, "in_ready"}, longint'(irdy), longint'(!(ov && !ordy)));
        held[d] = ov && !ordy;
        hp[d] = p;
        ht[d] = tg;
        if (!irdy) nirlow[d]++;
        if (ov && !ordy) stl[d]++;
        if (iv && irdy) begin
            e.p    = model(wa, wb, a, b, s);
            e.tag  = itg;
            e.cin  = cyc;
            e.sin  = stl[d];
            e.seen = 1'b0;
            sb[d].push_back(e);
        end
    endtask

    always @(negedge clk) begin
        mon(0, 5, 8, 8, ov0, or0, ir0, p0, ot0, iv0, a0, b0, s0, et0);
        mon(1, 5, 12, 5, ov1, or1, ir1, p1, ot1, iv1, a1, b1, s1, et1);
    end

    task automatic send0(input logic [7:0] a, input logic [7:0] b, input bit s);
        int k;
        iv0 = 1'b1; a0 = a; b0 = b; s0 = s; t0 = 4'($urandom);
        k = 0;
        @(negedge clk);
        while (!ir0 && k < 100) begin
            k++;
            @(negedge clk);
        end
        if (!ir0) chk("d0_send_timeout", 0, 1);
        @(posedge clk);
        #1;
        iv0 = 1'b0; a0 = '0; b0 = '0; s0 = 1'b0;
    endtask

    task automatic send1(input logic [11:0] a, input logic [4:0] b, input bit s);
        int k;
        iv1 = 1'b1; a1 = a; b1 = b; s1 = s; t1 = 4'($urandom);
        k = 0;
        @(negedge clk);
        while (!ir1 && k < 100) begin
            k++;
            @(negedge clk);
        end
        if (!ir1) chk("d1_send_timeout", 0, 1);
        @(posedge clk);
        #1;
        iv1 = 1'b0; a1 = '0; b1 = '0; s1 = 1'b0;
    endtask

    task automatic drain(input int d);
        int k;
        k = 0;
        while (sb[d].size() > 0 && k < 300) begin
            k++;
            @(posedge clk);
            #1;
        end
        chk($sformatf("d%0d_drain_left", d), longint'(sb[d].size()), 0);
    endtask

    initial begin
        iv0 = 0; a0 = '0; b0 = '0; s0 = 0; t0 = '0; or0 = 1;
        iv1 = 0; a1 = '0; b1 = '0; s1 = 0; t1 = '0; or1 = 1;
        for (int d = 0; d < 2; d++) begin
            stl[d] = 0; nirlow[d] = 0; npop[d] = 0; held[d] = 0;
            hp[d] = 0; ht[d] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ov0", longint'(ov0), 0);
        chk("rst_p0", longint'(p0), 0);
        chk("rst_tag0", longint'(ot0), 0);
        chk("rst_ir0", longint'(ir0), 1);
        chk("rst_ov1", longint'(ov1), 0);
        chk("rst_p1", longint'(p1), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        chk("pin_fe01", model(8, 8, 255, 255, 0), 'hFE01);
        chk("pin_zero", model(8, 8, 0, 200, 0), 0);
        chk("pin_4000", model(8, 8, 128, 128, 1), 'h4000);
        chk("pin_ff81", model(8, 8, 255, 127, 1), 'hFF81);
        chk("pin_c080", model(8, 8, 127, 128, 1), 'hC080);
        chk("pin_12x5", model(12, 5, 12'h800, 5'h10, 1), 17'h08000);

        send0(8'd255, 8'd255, 1'b0);
        send0(8'd0, 8'd200, 1'b0);
        send0(8'd128, 8'd128, 1'b1);
        send0(8'd255, 8'd127, 1'b1);
        send0(8'd127, 8'd128, 1'b1);
        send0(8'd255, 8'd255, 1'b1);
        send0(8'd255, 8'd255, 1'b0);
        drain(0);

        send0(8'd3, 8'd5, 1'b0);
        @(posedge clk);
        #1;
        send0(8'd7, 8'd9, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("bubble_v1", longint'(ov0), 1);
        @(posedge clk);
        #1;
        chk("bubble_v0", longint'(ov0), 0);
        @(posedge clk);
        #1;
        chk("bubble_v2", longint'(ov0), 1);
        drain(0);

        npop[0] = 0;
        nirlow[0] = 0;
        fork
            for (int i = 0; i < 20; i++)
                send0(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
            begin
                repeat (7) @(posedge clk);
                #1;
                or0 = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                or0 = 1'b1;
            end
        join
        drain(0);
        chk("stream_count", longint'(npop[0]), 20);
        chk("stream_stall_cycles", longint'(nirlow[0]), 3);

        for (int i = 0; i < 5; i++)
            send0(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
        chk("pre_rst_valid", longint'(ov0), 1);
        #2;
        rst_n = 1'b0;
        sb[0].delete();
        sb[1].delete();
        held[0] = 0;
        held[1] = 0;
        #1;
        chk("mid_rst_ov0", longint'(ov0), 0);
        chk("mid_rst_p0", longint'(p0), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("post_rst_ir0", longint'(ir0), 1);
        repeat (8) @(posedge clk);
        #1;

        done0 = 0;
        done1 = 0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send0(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
                end
                done0 = 1;
            end
            begin
                for (int i = 0; i < 200; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send1(12'($urandom), 5'($urandom), 1'($urandom_range(0, 1)));
                end
                done1 = 1;
            end
            begin
                while (!done0) begin
                    @(posedge clk);
                    #1;
                    or0 = ($urandom_range(0, 3) != 0);
                end
                or0 = 1'b1;
            end
            begin
                while (!done1) begin
                    @(posedge clk);
                    #1;
                    or1 = ($urandom_range(0, 3) != 0);
                end
                or1 = 1'b1;
            end
        join
        drain(0);
        drain(1);
        @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
